// File: rtl/jtag_debug_sys_instr_capture_ctrl_if.sv
// Avalon-MM slave bus between the JTAG-to-Avalon master and the capture block.
// master drives address/strobes/writedata; slave returns registered readdata.
interface jtag_debug_sys_instr_capture_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/jtag_debug_sys_instr_capture_ctrl.sv
// Captures core instruction words into a FIFO read by the JTAG host over Avalon-MM.
// Ports: clk, reset_n, bus (Avalon slave), instr_in/instr_valid (core tap), core_stall.
module jtag_debug_sys_instr_capture_ctrl #(
  parameter int IW    = 11,
  parameter int DEPTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  jtag_debug_sys_instr_capture_ctrl_if.slave     bus,
  input  logic [IW-1:0]                          instr_in,
  input  logic                                   instr_valid,
  output logic                                   core_stall
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, HOLD} state_t;

  state_t        state;
  state_t        state_nx;
  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          enable;
  logic          step_mode;
  logic          overflow;

  logic          rd;
  logic          wr;
  logic          wr_ctrl;
  logic          step_wr;
  logic          clr;
  logic          cap;
  logic          push;
  logic          pop;
  logic          empty;
  logic          full;
  logic [31:0]   status;
  logic [31:0]   rdata_nx;
  logic          unused_wd;

  assign rd      = bus.chipselect & bus.read;
  assign wr      = bus.chipselect & ~bus.write_n;
  assign wr_ctrl = wr & (bus.address == 2'd2);
  assign step_wr = wr & (bus.address == 2'd3);
  assign clr     = wr_ctrl & bus.writedata[2];

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  assign core_stall = (state == HOLD);
  assign cap = enable & instr_valid & ~core_stall;

  // A clear beats both a pop and a push in the same cycle.
  assign pop  = rd & (bus.address == 2'd0) & ~empty & ~clr;
  // A pop frees a slot, so a push into a full FIFO is legal then.
  assign push = cap & (~full | pop) & ~clr;

  assign status = {20'd0, core_stall, overflow, full, empty, 8'(count)};

  assign unused_wd = ^bus.writedata[31:3];

  always_comb begin
    rdata_nx = '0;
    unique case (bus.address)
      2'd0: if (pop) rdata_nx = 32'h8000_0000 | 32'(mem[rd_ptr]);
      2'd1: rdata_nx = status;
      2'd2: rdata_nx = {30'd0, step_mode, enable};
      2'd3: rdata_nx = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:  if (cap & step_mode) state_nx = HOLD;
      HOLD: if (step_wr | (wr_ctrl & ~bus.writedata[1])) state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      enable       <= 1'b0;
      step_mode    <= 1'b0;
      overflow     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.readdata <= '0;
    end else begin
      state <= state_nx;
      if (rd) bus.readdata <= rdata_nx;
      if (wr_ctrl) begin
        enable    <= bus.writedata[0];
        step_mode <= bus.writedata[1];
      end
      if (clr) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        if (push & ~pop)      count <= count + CW'(1);
        else if (pop & ~push) count <= count - CW'(1);
        if (cap & full & ~pop) overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= instr_in;
  end
endmodule

// File: tb/tb_jtag_debug_sys_instr_capture_ctrl.sv
// Self-checking bench for jtag_debug_sys_instr_capture_ctrl.
// Queue-based reference model plus directed literal checks.
module tb_jtag_debug_sys_instr_capture_ctrl;
  localparam int IW    = 11;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [IW-1:0] instr_in;
  logic          instr_valid;
  logic          core_stall;

  jtag_debug_sys_instr_capture_ctrl_if bus();

  jtag_debug_sys_instr_capture_ctrl #(
    .IW(IW),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .instr_in(instr_in),
    .instr_valid(instr_valid),
    .core_stall(core_stall)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          q[$];
  bit          m_ovf;
  bit          m_en;
  bit          m_step;
  bit          m_hold;
  logic [31:0] m_rdata;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_en = 0;
    m_step = 0;
    m_hold = 0;
    m_rdata = '0;
  endtask

  task automatic model_step();
    bit          r;
    bit          w;
    int          a;
    logic [31:0] wd;
    bit          clear;
    bit          capture;
    bit          room;
    bit          take;
    int          n;
    r = bus.chipselect && bus.read;
    w = bus.chipselect && !bus.write_n;
    a = int'(bus.address);
    wd = bus.writedata;
    clear = w && a == 2 && wd[2];
    capture = m_en && instr_valid && !m_hold;
    n = q.size();
    room = n < DEPTH;
    take = r && a == 0 && n != 0 && !clear;
    if (r) begin
      case (a)
        0: m_rdata = take ? 32'h8000_0000 + q[0] : 0;
        1: m_rdata = n + (n == 0 ? 256 : 0) + (n == DEPTH ? 512 : 0)
                     + (m_ovf ? 1024 : 0) + (m_hold ? 2048 : 0);
        2: m_rdata = (m_step ? 2 : 0) + (m_en ? 1 : 0);
        default: m_rdata = 0;
      endcase
    end
    if (clear) begin
      q.delete();
      m_ovf = 0;
    end else begin
      if (take) void'(q.pop_front());
      if (capture) begin
        if (room || take) q.push_back(int'(instr_in));
        else m_ovf = 1;
      end
    end
    if (!m_hold && capture && m_step) m_hold = 1;
    else if (m_hold && w && (a == 3 || (a == 2 && !wd[1]))) m_hold = 0;
    if (w && a == 2) begin
      m_en = wd[0];
      m_step = wd[1];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_readdata", bus.readdata, m_rdata);
      chk("cyc_core_stall", 32'(core_stall), 32'(m_hold));
    end
  end

  task automatic idle();
    bus.chipselect = 0;
    bus.read = 0;
    bus.write_n = 1;
    bus.address = 0;
    bus.writedata = 0;
    instr_valid = 0;
    instr_in = 0;
  endtask

  task automatic cyc(bit r, bit w, logic [1:0] a, logic [31:0] wd,
                     bit v, logic [IW-1:0] ins);
    bus.chipselect = r | w;
    bus.read = r;
    bus.write_n = !w;
    bus.address = a;
    bus.writedata = wd;
    instr_valid = v;
    instr_in = ins;
    @(negedge clk);
    idle();
  endtask

  task automatic wr_reg(logic [1:0] a, logic [31:0] wd);
    cyc(0, 1, a, wd, 0, '0);
  endtask

  task automatic push(logic [IW-1:0] ins);
    cyc(0, 0, 2'd0, 0, 1, ins);
  endtask

  task automatic rd_reg(string name, logic [1:0] a, logic [31:0] exp);
    cyc(1, 0, a, 0, 0, '0);
    chk(name, bus.readdata, exp);
  endtask

  initial begin
    idle();
    repeat (3) @(negedge clk);
    chk("rst_readdata", bus.readdata, 32'h0);
    chk("rst_stall", 32'(core_stall), 32'h0);
    #2 reset_n = 1'b1;
    @(negedge clk);
    rd_reg("rst_status", 2'd1, 32'h100);

    wr_reg(2'd2, 32'h1);
    for (int i = 1; i <= 8; i++) push(IW'(i));
    rd_reg("t2_full", 2'd1, 32'h208);
    push(11'h7FF);
    rd_reg("t2_ovf", 2'd1, 32'h608);
    for (int i = 1; i <= 8; i++) rd_reg("t2_drain", 2'd0, 32'h8000_0000 + i);
    rd_reg("t2_empty", 2'd0, 32'h0);
    rd_reg("t2_ctrl", 2'd2, 32'h1);

    wr_reg(2'd2, 32'h5);
    for (int i = 0; i < 5; i++) push(IW'(32'h10 + i));
    for (int i = 0; i < 5; i++) rd_reg("t3_pop", 2'd0, 32'h8000_0010 + i);
    for (int i = 0; i < 6; i++) push(IW'(32'h100 + i));
    for (int i = 0; i < 6; i++) rd_reg("t3_wrap", 2'd0, 32'h8000_0100 + i);
    rd_reg("t3_status", 2'd1, 32'h100);

    for (int i = 1; i <= 8; i++) push(IW'(i));
    cyc(1, 0, 2'd0, 0, 1, 11'h155);
    chk("t4_pop", bus.readdata, 32'h8000_0001);
    rd_reg("t4_status", 2'd1, 32'h208);
    for (int i = 2; i <= 8; i++) rd_reg("t4_drain", 2'd0, 32'h8000_0000 + i);
    rd_reg("t4_last", 2'd0, 32'h8000_0155);
    rd_reg("t4_end", 2'd1, 32'h100);

    wr_reg(2'd2, 32'h3);
    push(11'h0AA);
    chk("t5_stall_on", 32'(core_stall), 32'h1);
    push(11'h0BB);
    chk("t5_stall_held", 32'(core_stall), 32'h1);
    rd_reg("t5_hold_status", 2'd1, 32'h801);
    rd_reg("t5_step_rd", 2'd3, 32'h0);
    wr_reg(2'd3, 32'h0);
    chk("t5_stall_off", 32'(core_stall), 32'h0);
    rd_reg("t5_status", 2'd1, 32'h001);
    rd_reg("t5_data", 2'd0, 32'h8000_00AA);

    wr_reg(2'd2, 32'h1);
    for (int i = 0; i < 9; i++) push(IW'(32'h20 + i));
    for (int i = 0; i < 5; i++) rd_reg("t6_pop", 2'd0, 32'h8000_0020 + i);
    rd_reg("t6_pre", 2'd1, 32'h403);
    cyc(0, 1, 2'd2, 32'h5, 1, 11'h3FF);
    rd_reg("t6_status", 2'd1, 32'h100);
    rd_reg("t6_ctrl", 2'd2, 32'h1);

    wr_reg(2'd2, 32'h3);
    push(11'h055);
    rd_reg("t1_pre", 2'd1, 32'h801);
    #2 reset_n = 1'b0;
    #1;
    chk("t1_async_readdata", bus.readdata, 32'h0);
    chk("t1_async_stall", 32'(core_stall), 32'h0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    rd_reg("t1_post_status", 2'd1, 32'h100);
    rd_reg("t1_post_ctrl", 2'd2, 32'h0);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
